acc_ctrl: RTL and testbench

- Control sequencer that drives the accumulator's write interface (SelAcc, loadAcc, imm) and the register file and ALU around it. It is the initiating end of the accumulator load protocol.
- Owns the program counter, instruction register and latched ALU flags.
- Runs a fixed 3-cycle FETCH/DECODE/EXEC sequence per 8-bit instruction: opcode in [7:4], operand in [3:0].

---
 rtl/acc_ctrl.sv | 142 ++++++++++++++
 tb/tb_acc_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_ctrl.sv
// acc_ctrl: FETCH/DECODE/EXEC sequencer for the accumulator machine.
// Owns pc, ir and the latched ALU flags. Drives the accumulator load port
// (SelAcc/loadAcc/imm), the register file (reg_addr/reg_we) and alu_op.
//
// Handshake: acc_ctrl is the initiating end of the accumulator load protocol.
// SelAcc and imm are stable for the whole EXEC cycle while loadAcc (or reg_we)
// is high. The receiver captures on the rising edge that ends EXEC. There is
// no back-pressure. The strobe is high for exactly one cycle per instruction.
module acc_ctrl #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic       clk,
   input  logic       CLB,
   input  logic       run,
   input  logic [7:0] instr,
   input  logic       alu_zero,
   input  logic       alu_carry,
   output logic [7:0] pc,
   output logic [3:0] imm,
   output logic [1:0] SelAcc,
   output logic       loadAcc,
   output logic [2:0] alu_op,
   output logic [3:0] reg_addr,
   output logic       reg_we,
   output logic       zero_flag,
   output logic       carry_flag,
   output logic       halted,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_DECODE = 2'd1,
      S_EXEC   = 2'd2,
      S_HALT   = 2'd3
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] ir;
   logic [3:0] opcode;
   logic [7:0] pc_inc;
   logic       is_alu;
   logic       take_branch;
   logic [1:0] dec_sel;
   logic       dec_ld;
   logic       dec_we;
   logic [2:0] dec_aop;

   assign opcode    = ir[7:4];
   assign imm       = ir[3:0];
   assign reg_addr  = ir[3:0];
   assign pc_inc    = pc + 8'd1;
   assign state_dbg = state;
   assign is_alu    = (opcode >= 4'h4) && (opcode <= 4'hB);

   // Branch decision uses the flags as held before EXEC; pc is already incremented.
   assign take_branch = (opcode == 4'hC) ||
                        ((opcode == 4'hD) && zero_flag) ||
                        ((opcode == 4'hE) && carry_flag);

   // State register.
   always_ff @(posedge clk or negedge CLB) begin
      if (!CLB) state <= S_FETCH;
      else      state <= state_nxt;
   end

   // Next-state logic: 3-cycle sequence, HLT parks in the absorbing HALT state.
   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:  if (run) state_nxt = S_DECODE;
         S_DECODE: state_nxt = S_EXEC;
         S_EXEC:   state_nxt = (opcode == 4'hF) ? S_HALT : S_FETCH;
         S_HALT:   state_nxt = S_HALT;
         default:  state_nxt = S_FETCH;
      endcase
   end

   // Instruction decode from ir; registered into the outputs at the DECODE edge.
   always_comb begin
      dec_sel = 2'b11;
      dec_ld  = 1'b0;
      dec_we  = 1'b0;
      dec_aop = 3'b000;
      case (opcode)
         4'h1: begin dec_sel = 2'b10; dec_ld = 1'b1; end
         4'h2: begin dec_sel = 2'b01; dec_ld = 1'b1; end
         4'h3: dec_we = 1'b1;
         default: begin
            if (is_alu) begin
               dec_sel = 2'b00;
               dec_ld  = 1'b1;
               dec_aop = 3'(opcode - 4'h4);
            end
         end
      endcase
   end

   // Datapath registers: pc, ir, strobes, flags, halted. Reset abandons any instruction.
   always_ff @(posedge clk or negedge CLB) begin
      if (!CLB) begin
         pc         <= RESET_PC;
         ir         <= 8'h00;
         SelAcc     <= 2'b11;
         loadAcc    <= 1'b0;
         reg_we     <= 1'b0;
         alu_op     <= 3'b000;
         zero_flag  <= 1'b0;
         carry_flag <= 1'b0;
         halted     <= 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               if (run) begin
                  ir <= instr;
                  pc <= pc_inc;
               end
            end
            S_DECODE: begin
               SelAcc  <= dec_sel;
               loadAcc <= dec_ld;
               reg_we  <= dec_we;
               alu_op  <= dec_aop;
            end
            S_EXEC: begin
               SelAcc  <= 2'b11;
               loadAcc <= 1'b0;
               reg_we  <= 1'b0;
               if (is_alu) begin
                  zero_flag  <= alu_zero;
                  carry_flag <= alu_carry;
               end
               if (take_branch) pc <= {pc[7:4], ir[3:0]};
               if (opcode == 4'hF) halted <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_acc_ctrl.sv
// tb_acc_ctrl: self-checking bench for acc_ctrl. An instruction-level model
// pushes the expected EXEC-cycle outputs and post-instruction state into
// queues as each instruction is driven; they are popped and compared when the
// DUT reaches the corresponding cycle.
module tb_acc_ctrl;

   logic       clk = 1'b0;
   logic       CLB;
   logic       run;
   logic [7:0] instr;
   logic       alu_zero;
   logic       alu_carry;
   logic [7:0] pc;
   logic [3:0] imm;
   logic [1:0] SelAcc;
   logic       loadAcc;
   logic [2:0] alu_op;
   logic [3:0] reg_addr;
   logic       reg_we;
   logic       zero_flag;
   logic       carry_flag;
   logic       halted;
   logic [1:0] state_dbg;

   int checks = 0;
   int errors = 0;

   logic [10:0] exp_q[$];   // {SelAcc, loadAcc, reg_we, alu_op, imm}
   logic [10:0] post_q[$];  // {pc, zero_flag, carry_flag, halted}

   logic [7:0] m_pc;
   logic       m_zf;
   logic       m_cf;

   acc_ctrl #(.RESET_PC(8'h00)) dut (
      .clk(clk), .CLB(CLB), .run(run), .instr(instr),
      .alu_zero(alu_zero), .alu_carry(alu_carry),
      .pc(pc), .imm(imm), .SelAcc(SelAcc), .loadAcc(loadAcc),
      .alu_op(alu_op), .reg_addr(reg_addr), .reg_we(reg_we),
      .zero_flag(zero_flag), .carry_flag(carry_flag),
      .halted(halted), .state_dbg(state_dbg)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_ld"},  32'(loadAcc), 32'd0);
      chk({tag, "_we"},  32'(reg_we),  32'd0);
      chk({tag, "_sel"}, 32'(SelAcc),  32'd3);
   endtask

   // Pulse CLB low, check reset values, release so the next edge is a FETCH.
   task automatic do_reset();
      run = 1'b0;
      CLB = 1'b0;
      #1;
      chk("rst_pc", 32'(pc), 32'h00);
      chk_idle("rst");
      chk("rst_aop", 32'(alu_op), 32'd0);
      chk("rst_zf", 32'(zero_flag), 32'd0);
      chk("rst_cf", 32'(carry_flag), 32'd0);
      chk("rst_halt", 32'(halted), 32'd0);
      tick();
      CLB = 1'b1;
      m_pc = 8'h00;
      m_zf = 1'b0;
      m_cf = 1'b0;
   endtask

   // Drive one instruction through FETCH/DECODE/EXEC and score it.
   task automatic do_instr(input logic [7:0] op, input logic az, input logic ac);
      logic [3:0]  opc;
      logic [7:0]  ipc;
      logic [7:0]  npc;
      logic [1:0]  sel;
      logic        ld;
      logic        we;
      logic [2:0]  aop;
      logic        zf;
      logic        cf;
      logic        hl;
      logic [10:0] e;
      logic [10:0] p;
      opc = op[7:4];
      ipc = m_pc + 8'd1;
      npc = ipc;
      sel = 2'b11; ld = 1'b0; we = 1'b0; aop = 3'd0;
      zf = m_zf; cf = m_cf; hl = 1'b0;
      case (opc)
         4'h0: ;
         4'h1: begin sel = 2'b10; ld = 1'b1; end
         4'h2: begin sel = 2'b01; ld = 1'b1; end
         4'h3: we = 1'b1;
         4'hC: npc = {ipc[7:4], op[3:0]};
         4'hD: if (m_zf) npc = {ipc[7:4], op[3:0]};
         4'hE: if (m_cf) npc = {ipc[7:4], op[3:0]};
         4'hF: hl = 1'b1;
         default: begin
            sel = 2'b00; ld = 1'b1; aop = 3'(opc - 4'd4);
            zf = az; cf = ac;
         end
      endcase
      exp_q.push_back({sel, ld, we, aop, op[3:0]});
      post_q.push_back({npc, zf, cf, hl});

      // FETCH
      instr = op; run = 1'b1; alu_zero = az; alu_carry = ac;
      tick();
      // DECODE: pc already incremented, no strobes yet; run no longer matters
      chk("dec_pc", 32'(pc), 32'(ipc));
      chk_idle("dec");
      instr = 8'($urandom);
      run = 1'($urandom_range(0, 1));
      tick();
      // EXEC: strobes valid
      e = exp_q.pop_front();
      chk("ex_sel", 32'(SelAcc), 32'(e[10:9]));
      chk("ex_ld", 32'(loadAcc), 32'(e[8]));
      chk("ex_we", 32'(reg_we), 32'(e[7]));
      chk("ex_imm", 32'(imm), 32'(e[3:0]));
      chk("ex_raddr", 32'(reg_addr), 32'(e[3:0]));
      if (e[8] && e[10:9] == 2'b00) chk("ex_aop", 32'(alu_op), 32'(e[6:4]));
      chk("ex_pc", 32'(pc), 32'(ipc));
      tick();
      // Back in FETCH (or HALT)
      p = post_q.pop_front();
      chk("post_pc", 32'(pc), 32'(p[10:3]));
      chk("post_zf", 32'(zero_flag), 32'(p[2]));
      chk("post_cf", 32'(carry_flag), 32'(p[1]));
      chk("post_halt", 32'(halted), 32'(p[0]));
      chk_idle("post");
      m_pc = p[10:3];
      m_zf = p[2];
      m_cf = p[1];
   endtask

   initial begin
      logic [7:0] rop;
      int         guard;
      CLB = 1'b0; run = 1'b0; instr = 8'h00; alu_zero = 1'b0; alu_carry = 1'b0;
      m_pc = 8'h00; m_zf = 1'b0; m_cf = 1'b0;
      repeat (2) tick();
      do_reset();

      // LDI 7: one-cycle strobe, SelAcc = 10, imm = 7
      do_instr(8'h17, 1'b0, 1'b0);

      // Reset mid-EXEC of an ADD, then idle with run = 0
      instr = 8'h40; run = 1'b1; alu_zero = 1'b1; alu_carry = 1'b1;
      tick(); tick();
      chk("mid_ld", 32'(loadAcc), 32'd1);
      CLB = 1'b0;
      #1;
      chk("mid_rst_pc", 32'(pc), 32'h00);
      chk_idle("mid_rst");
      tick();
      CLB = 1'b1; run = 1'b0;
      repeat (5) begin
         tick();
         chk("idle_pc", 32'(pc), 32'h00);
         chk_idle("idle");
         chk("idle_zf", 32'(zero_flag), 32'd0);
         chk("idle_cf", 32'(carry_flag), 32'd0);
         chk("idle_halt", 32'(halted), 32'd0);
      end
      m_pc = 8'h00; m_zf = 1'b0; m_cf = 1'b0;

      // STR 5 then LDR 5
      do_instr(8'h35, 1'b0, 1'b0);
      do_instr(8'h25, 1'b0, 1'b0);

      // SUB with zero, LDI preserves flag, JZ 9 taken
      do_reset();
      do_instr(8'h52, 1'b1, 1'b0);
      do_instr(8'h13, 1'b0, 1'b1);
      do_instr(8'hD9, 1'b0, 1'b1);
      // Same with nonzero result: JZ falls through to 03
      do_reset();
      do_instr(8'h52, 1'b0, 1'b0);
      do_instr(8'h13, 1'b1, 1'b1);
      do_instr(8'hD9, 1'b1, 1'b1);

      // Page boundary: JMP F at 00 -> 0F, JMP 4 at 0F -> 14
      do_reset();
      do_instr(8'hCF, 1'b0, 1'b0);
      do_instr(8'hC4, 1'b0, 1'b0);
      chk("page_pc", 32'(pc), 32'h14);

      // Random non-branch instructions up to 0xFF, then NOP wraps to 00
      guard = 0;
      while (m_pc != 8'hFF && guard < 300) begin
         rop = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 15))};
         do_instr(rop, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         guard++;
      end
      chk("walk_bound", 32'(m_pc), 32'hFF);
      do_instr(8'h00, 1'b0, 1'b0);
      chk("wrap_pc", 32'(pc), 32'h00);

      // Carry flag and JC taken, JZ not taken
      do_instr(8'h40, 1'b0, 1'b1);
      do_instr(8'hE5, 1'b1, 1'b0);
      do_instr(8'hD7, 1'b1, 1'b0);

      // HLT at 06
      do_reset();
      repeat (6) begin
         rop = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 15))};
         do_instr(rop, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      do_instr(8'hF0, 1'b0, 1'b0);
      repeat (20) begin
         instr = 8'($urandom);
         run = 1'b1;
         tick();
         chk("halt_pc", 32'(pc), 32'h07);
         chk("halt_flag", 32'(halted), 32'd1);
         chk_idle("halt");
      end
      do_reset();
      #1;
      chk("unhalt_pc", 32'(pc), 32'h00);
      chk("unhalt_flag", 32'(halted), 32'd0);

      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
      chk("post_q_empty", 32'(post_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
